// File: rtl/glyph_renderer_if.sv
// glyph_renderer_if
// Point stream from the glyph renderer to the framebuffer pixel writer.
//   out_x     : screen x of the current point
//   out_y     : screen y of the current point
//   out_color : 1 = foreground pixel, 0 = background fill pixel
//   out_valid : out_x/out_y/out_color carry a point
//   out_ready : writer accepts the current point this cycle
// master = renderer side, slave = pixel writer side.
interface glyph_renderer_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic           out_color;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output out_x, out_y, out_color, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_x, out_y, out_color, out_valid,
    output out_ready
  );
endinterface

// File: rtl/glyph_renderer.sv
// glyph_renderer
// Walks a latched FONT_W x FONT_H glyph bitmap and emits scaled screen points,
// one per cycle, over a valid/ready stream. With fill_bg set, clear pixels are
// emitted too and tagged with colour 0.
//   clock, reset : system clock, synchronous active-high reset
//   start        : begin a render (only honoured while idle)
//   glyph_bits   : bitmap, bit i = row i/FONT_W, col i%FONT_W, bit 0 top-left
//   origin_x/y   : screen position of the glyph's top-left corner
//   scale        : screen pixels per glyph pixel edge (0 behaves as 1)
//   fill_bg      : also emit background pixels
//   pix          : point stream (out_x, out_y, out_color, out_valid, out_ready)
//   busy         : high whenever not idle
//   done         : one-cycle pulse after the last point is accepted
module glyph_renderer #(
  parameter int FONT_W  = 5,
  parameter int FONT_H  = 7,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int SCALE_W = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [FONT_W*FONT_H-1:0]   glyph_bits,
  input  logic [X_W-1:0]             origin_x,
  input  logic [Y_W-1:0]             origin_y,
  input  logic [SCALE_W-1:0]         scale,
  input  logic                       fill_bg,
  glyph_renderer_if.master           pix,
  output logic                       busy,
  output logic                       done
);

  localparam int NPIX  = FONT_W * FONT_H;
  localparam int IDX_W = $clog2(NPIX);
  localparam int COL_W = $clog2(FONT_W + 1);
  localparam int ROW_W = $clog2(FONT_H + 1);
  // Wide enough that origin + col*scale + sx never overflows before truncation.
  localparam int PX_W  = X_W + COL_W + SCALE_W + 1;
  localparam int PY_W  = Y_W + ROW_W + SCALE_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FONT_W - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t               r_state;
  logic [NPIX-1:0]      r_glyph;
  logic [X_W-1:0]       r_originX;
  logic [Y_W-1:0]       r_originY;
  logic [SCALE_W-1:0]   r_scale;
  logic                 r_fill;
  logic [IDX_W-1:0]     r_idx;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic [SCALE_W-1:0]   r_sx;
  logic [SCALE_W-1:0]   r_sy;
  logic [X_W-1:0]       r_outX;
  logic [Y_W-1:0]       r_outY;
  logic                 r_outColor;
  logic                 r_outValid;

  state_t               w_nextState;
  logic [IDX_W-1:0]     w_nextIdx;
  logic [COL_W-1:0]     w_nextCol;
  logic [ROW_W-1:0]     w_nextRow;
  logic [SCALE_W-1:0]   w_nextSx;
  logic [SCALE_W-1:0]   w_nextSy;
  logic                 w_step;
  logic                 w_drawn;
  logic                 w_lastIdx;
  logic [SCALE_W-1:0]   w_scaleLast;
  logic [PX_W-1:0]      w_xFull;
  logic [PY_W-1:0]      w_yFull;

  // Next-state logic: walks pixels in SCAN and sub-points in EMIT. The output
  // point is computed from the *next* counters so the registered outputs line
  // up with the state they belong to.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_nextCol   = r_col;
    w_nextRow   = r_row;
    w_nextSx    = r_sx;
    w_nextSy    = r_sy;
    w_step      = 1'b0;
    w_drawn     = r_glyph[r_idx] | r_fill;
    w_lastIdx   = (r_idx == LAST_IDX);
    w_scaleLast = r_scale - SCALE_W'(1);

    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = SCAN;
          w_nextIdx   = '0;
          w_nextCol   = '0;
          w_nextRow   = '0;
          w_nextSx    = '0;
          w_nextSy    = '0;
        end
      end
      SCAN: begin
        if (w_drawn) begin
          w_nextState = EMIT;
          w_nextSx    = '0;
          w_nextSy    = '0;
        end else begin
          w_step      = 1'b1;
          w_nextState = w_lastIdx ? DONE : SCAN;
        end
      end
      EMIT: begin
        if (pix.out_ready) begin
          if (r_sx != w_scaleLast) begin
            w_nextSx = r_sx + SCALE_W'(1);
          end else if (r_sy != w_scaleLast) begin
            w_nextSx = '0;
            w_nextSy = r_sy + SCALE_W'(1);
          end else begin
            w_nextSx    = '0;
            w_nextSy    = '0;
            w_step      = 1'b1;
            w_nextState = w_lastIdx ? DONE : SCAN;
          end
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    // Row/column are tracked alongside the index to avoid a divider.
    if (w_step && !w_lastIdx) begin
      w_nextIdx = r_idx + IDX_W'(1);
      if (r_col == COL_LAST) begin
        w_nextCol = '0;
        w_nextRow = r_row + ROW_W'(1);
      end else begin
        w_nextCol = r_col + COL_W'(1);
      end
    end

    w_xFull = PX_W'(r_originX) + PX_W'(w_nextCol) * PX_W'(r_scale) + PX_W'(w_nextSx);
    w_yFull = PY_W'(r_originY) + PY_W'(w_nextRow) * PY_W'(r_scale) + PY_W'(w_nextSy);
  end

  // State, counters and registered point outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_outX     <= '0;
      r_outY     <= '0;
      r_outColor <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_idx      <= w_nextIdx;
      r_col      <= w_nextCol;
      r_row      <= w_nextRow;
      r_sx       <= w_nextSx;
      r_sy       <= w_nextSy;
      r_outValid <= (w_nextState == EMIT);
      if (w_nextState == EMIT) begin
        r_outX     <= w_xFull[X_W-1:0];
        r_outY     <= w_yFull[Y_W-1:0];
        r_outColor <= r_glyph[w_nextIdx];
      end else begin
        r_outX     <= '0;
        r_outY     <= '0;
        r_outColor <= 1'b0;
      end
    end
  end

  // Render parameters are captured once at start so the decoder may move on.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_glyph   <= '0;
      r_originX <= '0;
      r_originY <= '0;
      r_scale   <= SCALE_W'(1);
      r_fill    <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_glyph   <= glyph_bits;
      r_originX <= origin_x;
      r_originY <= origin_y;
      r_scale   <= (scale == '0) ? SCALE_W'(1) : scale;
      r_fill    <= fill_bg;
    end
  end

  assign pix.out_x     = r_outX;
  assign pix.out_y     = r_outY;
  assign pix.out_color = r_outColor;
  assign pix.out_valid = r_outValid;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);

endmodule

// File: tb/tb_glyph_renderer.sv
// tb_glyph_renderer
// Directed self-checking bench for glyph_renderer. Each test task starts a
// render, collects the accepted points and control timing, and compares them
// against hand-computed expectations.
module tb_glyph_renderer;
  localparam int FONT_W  = 5;
  localparam int FONT_H  = 7;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int SCALE_W = 3;
  localparam int NPIX    = FONT_W * FONT_H;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [NPIX-1:0]    glyph_bits;
  logic [X_W-1:0]     origin_x;
  logic [Y_W-1:0]     origin_y;
  logic [SCALE_W-1:0] scale;
  logic               fill_bg;
  logic               busy;
  logic               done;

  glyph_renderer_if #(.X_W(X_W), .Y_W(Y_W)) pix();

  glyph_renderer #(
    .FONT_W(FONT_W), .FONT_H(FONT_H), .X_W(X_W), .Y_W(Y_W), .SCALE_W(SCALE_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .glyph_bits(glyph_bits),
    .origin_x(origin_x), .origin_y(origin_y), .scale(scale), .fill_bg(fill_bg),
    .pix(pix), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int ptsX[$];
  int ptsY[$];
  int ptsC[$];
  int stallX[$];
  int stallY[$];
  int doneCycle, doneCount, busyFirst, busyLast, busyCount;
  int stallCycles = 0;
  int pulseA = -1;
  int pulseB = -1;

  function automatic int qAt(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Starts a render at the next clock edge, then samples every cycle on the
  // falling edge. Cycle k=1 is the first cycle after the start edge. Inputs are
  // scrambled right after start so any re-sampling shows up in the results.
  task automatic applyStimulus(input logic [NPIX-1:0] g, input int ox, input int oy,
                               input int sc, input bit fill, input int budget);
    int stallLeft;
    bit seenValid;
    ptsX.delete(); ptsY.delete(); ptsC.delete();
    stallX.delete(); stallY.delete();
    doneCycle = -1; doneCount = 0;
    busyFirst = -1; busyLast = -1; busyCount = 0;
    stallLeft = 0; seenValid = 0;
    @(negedge clock);
    glyph_bits    = g;
    origin_x      = X_W'(ox);
    origin_y      = Y_W'(oy);
    scale         = SCALE_W'(sc);
    fill_bg       = fill;
    pix.out_ready = 1'b1;
    start         = 1'b1;
    @(negedge clock);
    glyph_bits = ~g;
    origin_x   = origin_x + X_W'(3);
    origin_y   = origin_y + Y_W'(5);
    scale      = scale + SCALE_W'(1);
    fill_bg    = ~fill;
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) @(negedge clock);
      start = (k == pulseA) || (k == pulseB);
      if (pix.out_valid && !seenValid) begin
        seenValid = 1'b1;
        stallLeft = stallCycles;
      end
      if (stallLeft > 0) begin
        pix.out_ready = 1'b0;
        stallLeft--;
        if (pix.out_valid) begin
          stallX.push_back(int'(pix.out_x));
          stallY.push_back(int'(pix.out_y));
        end
      end else begin
        pix.out_ready = 1'b1;
      end
      if (pix.out_valid && pix.out_ready) begin
        ptsX.push_back(int'(pix.out_x));
        ptsY.push_back(int'(pix.out_y));
        ptsC.push_back(int'(pix.out_color));
      end
      if (busy) begin
        if (busyFirst < 0) busyFirst = k;
        busyLast = k;
        busyCount++;
      end
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = k;
      end
      if (doneCycle >= 0 && k >= doneCycle + 2) break;
    end
    start         = 1'b0;
    pix.out_ready = 1'b1;
    stallCycles   = 0;
    pulseA        = -1;
    pulseB        = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (pix.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: valid=%b busy=%b done=%b expected 0 0 0",
               pix.out_valid, busy, done);
    end
    total++;
    if (pix.out_x !== '0 || pix.out_y !== '0 || pix.out_color !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_point: (%0d,%0d,%b) expected (0,0,0)",
               pix.out_x, pix.out_y, pix.out_color);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || pix.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: busy=%b valid=%b expected 0 0", busy, pix.out_valid);
    end
  endtask

  task automatic test_empty();
    applyStimulus('0, 0, 0, 1, 1'b0, 200);
    total++;
    if (ptsX.size() !== 0) begin
      bad++; $display("[TB] FAIL empty_points: got %0d expected 0", ptsX.size());
    end
    total++;
    if (doneCycle !== 36 || doneCount !== 1) begin
      bad++; $display("[TB] FAIL empty_done: cycle=%0d count=%0d expected 36 1", doneCycle, doneCount);
    end
    total++;
    if (busyFirst !== 1 || busyLast !== 36 || busyCount !== 36) begin
      bad++;
      $display("[TB] FAIL empty_busy: first=%0d last=%0d count=%0d expected 1 36 36",
               busyFirst, busyLast, busyCount);
    end
  endtask

  task automatic test_single();
    int ex[4] = '{10, 11, 10, 11};
    int ey[4] = '{20, 20, 21, 21};
    applyStimulus(NPIX'(1), 10, 20, 2, 1'b0, 200);
    total++;
    if (ptsX.size() !== 4) begin
      bad++; $display("[TB] FAIL single_count: got %0d expected 4", ptsX.size());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (qAt(ptsX, i) !== ex[i] || qAt(ptsY, i) !== ey[i] || qAt(ptsC, i) !== 1) begin
        bad++;
        $display("[TB] FAIL single_pt%0d: got (%0d,%0d,%0d) expected (%0d,%0d,1)",
                 i, qAt(ptsX, i), qAt(ptsY, i), qAt(ptsC, i), ex[i], ey[i]);
      end
    end
    total++;
    if (doneCycle !== 40) begin
      bad++; $display("[TB] FAIL single_done: cycle=%0d expected 40", doneCycle);
    end
  endtask

  task automatic test_last_pixel();
    logic [NPIX-1:0] g;
    g = NPIX'(1) << 34;
    applyStimulus(g, 0, 0, 0, 1'b0, 200);
    total++;
    if (ptsX.size() !== 1 || qAt(ptsX, 0) !== 4 || qAt(ptsY, 0) !== 6 || qAt(ptsC, 0) !== 1) begin
      bad++;
      $display("[TB] FAIL last_pixel: n=%0d first=(%0d,%0d,%0d) expected n=1 (4,6,1)",
               ptsX.size(), qAt(ptsX, 0), qAt(ptsY, 0), qAt(ptsC, 0));
    end
    total++;
    if (doneCycle !== 37) begin
      bad++; $display("[TB] FAIL last_pixel_done: cycle=%0d expected 37", doneCycle);
    end
  endtask

  task automatic test_fill_bg();
    applyStimulus('0, 30, 40, 1, 1'b1, 300);
    total++;
    if (ptsX.size() !== 35) begin
      bad++; $display("[TB] FAIL fill_count: got %0d expected 35", ptsX.size());
    end
    for (int i = 0; i < 35; i++) begin
      total++;
      if (qAt(ptsX, i) !== 30 + i % 5 || qAt(ptsY, i) !== 40 + i / 5 || qAt(ptsC, i) !== 0) begin
        bad++;
        $display("[TB] FAIL fill_pt%0d: got (%0d,%0d,%0d) expected (%0d,%0d,0)",
                 i, qAt(ptsX, i), qAt(ptsY, i), qAt(ptsC, i), 30 + i % 5, 40 + i / 5);
      end
    end
    total++;
    if (doneCycle !== 71) begin
      bad++; $display("[TB] FAIL fill_done: cycle=%0d expected 71", doneCycle);
    end
  endtask

  task automatic test_backpressure();
    int ex[4] = '{50, 51, 50, 51};
    int ey[4] = '{60, 60, 61, 61};
    stallCycles = 3;
    applyStimulus(NPIX'(1), 50, 60, 2, 1'b0, 200);
    total++;
    if (stallX.size() !== 3) begin
      bad++; $display("[TB] FAIL bp_stall_len: got %0d expected 3", stallX.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (qAt(stallX, i) !== 50 || qAt(stallY, i) !== 60) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d: got (%0d,%0d) expected (50,60)", i, qAt(stallX, i), qAt(stallY, i));
      end
    end
    total++;
    if (ptsX.size() !== 4) begin
      bad++; $display("[TB] FAIL bp_count: got %0d expected 4", ptsX.size());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (qAt(ptsX, i) !== ex[i] || qAt(ptsY, i) !== ey[i]) begin
        bad++;
        $display("[TB] FAIL bp_pt%0d: got (%0d,%0d) expected (%0d,%0d)",
                 i, qAt(ptsX, i), qAt(ptsY, i), ex[i], ey[i]);
      end
    end
    total++;
    if (doneCycle !== 43) begin
      bad++; $display("[TB] FAIL bp_done: cycle=%0d expected 43", doneCycle);
    end
  endtask

  task automatic test_wrap();
    int ex[4] = '{0, 1, 0, 1};
    int ey[4] = '{127, 127, 0, 0};
    applyStimulus(NPIX'(2), 254, 127, 2, 1'b0, 200);
    total++;
    if (ptsX.size() !== 4) begin
      bad++; $display("[TB] FAIL wrap_count: got %0d expected 4", ptsX.size());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (qAt(ptsX, i) !== ex[i] || qAt(ptsY, i) !== ey[i]) begin
        bad++;
        $display("[TB] FAIL wrap_pt%0d: got (%0d,%0d) expected (%0d,%0d)",
                 i, qAt(ptsX, i), qAt(ptsY, i), ex[i], ey[i]);
      end
    end
    total++;
    if (doneCycle !== 40) begin
      bad++; $display("[TB] FAIL wrap_done: cycle=%0d expected 40", doneCycle);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit idleOk;
    @(negedge clock);
    glyph_bits = NPIX'(1); origin_x = 8'd9; origin_y = 7'd9; scale = 3'd3; fill_bg = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (pix.out_valid) seen = 1'b1;
      else @(negedge clock);
    end
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL rmid_valid: out_valid=0 after 10 cycles expected 1");
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (pix.out_valid !== 1'b0 || pix.out_x !== '0 || pix.out_y !== '0 ||
        pix.out_color !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rmid_clear: valid=%b x=%0d y=%0d c=%b busy=%b done=%b expected all 0",
               pix.out_valid, pix.out_x, pix.out_y, pix.out_color, busy, done);
    end
    reset = 1'b0;
    idleOk = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (busy !== 1'b0 || pix.out_valid !== 1'b0) idleOk = 1'b0;
    end
    total++;
    if (!idleOk) begin
      bad++; $display("[TB] FAIL rmid_idle: busy/valid rose after reset, expected 0");
    end
    applyStimulus(NPIX'(1), 1, 2, 1, 1'b0, 200);
    total++;
    if (ptsX.size() !== 1 || qAt(ptsX, 0) !== 1 || qAt(ptsY, 0) !== 2 || doneCycle !== 37) begin
      bad++;
      $display("[TB] FAIL rmid_recover: n=%0d pt=(%0d,%0d) done=%0d expected n=1 (1,2) done=37",
               ptsX.size(), qAt(ptsX, 0), qAt(ptsY, 0), doneCycle);
    end
  endtask

  task automatic test_start_busy();
    pulseA = 5;
    pulseB = 36;
    applyStimulus('0, 0, 0, 1, 1'b0, 200);
    total++;
    if (ptsX.size() !== 0 || doneCycle !== 36 || doneCount !== 1) begin
      bad++;
      $display("[TB] FAIL busy_start: n=%0d done=%0d count=%0d expected 0 36 1",
               ptsX.size(), doneCycle, doneCount);
    end
    total++;
    if (busyLast !== 36 || busyCount !== 36) begin
      bad++;
      $display("[TB] FAIL done_start: busyLast=%0d busyCount=%0d expected 36 36", busyLast, busyCount);
    end
  endtask

  task automatic test_start_after_done();
    bit seen;
    pulseA = 37;
    applyStimulus('0, 0, 0, 1, 1'b0, 200);
    total++;
    if (doneCycle !== 36 || busyLast !== 38 || busyCount !== 37) begin
      bad++;
      $display("[TB] FAIL idle_start: done=%0d busyLast=%0d busyCount=%0d expected 36 38 37",
               doneCycle, busyLast, busyCount);
    end
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL idle_start_drain: done=0 after 400 cycles expected 1");
    end
    @(negedge clock);
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    glyph_bits    = '0;
    origin_x      = '0;
    origin_y      = '0;
    scale         = '0;
    fill_bg       = 1'b0;
    pix.out_ready = 1'b1;
    test_reset();
    test_empty();
    test_single();
    test_last_pixel();
    test_fill_bg();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    test_start_after_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glyph_renderer.md
Name: glyph_renderer

Overview:
Parametrised successor to the single-size character renderer. Takes a latched glyph bitmap of FONT_W x FONT_H pixels and emits a stream of scaled screen points, one per cycle, with a valid/ready handshake toward the framebuffer writer. It adds an optional background-fill mode that tags each point with a colour bit, and it reports completion with a one-cycle done pulse. It sits between the character decoder, which supplies glyph_bits, and the pixel writer in the rendering pipeline.

Parameters:
FONT_W, 5, glyph width in pixels
FONT_H, 7, glyph height in pixels
X_W, 8, screen x coordinate width
Y_W, 7, screen y coordinate width
SCALE_W, 3, width of scale input

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  request render; sampled only in IDLE
glyph_bits  in  FONT_W*FONT_H  bitmap; bit i = row i/FONT_W, col i%FONT_W; bit 0 is top-left
origin_x  in  X_W  top-left x of glyph
origin_y  in  Y_W  top-left y of glyph
scale  in  SCALE_W  screen pixels per glyph pixel edge; 0 treated as 1
fill_bg  in  1  1 = emit clear pixels too, with out_color=0
out_ready  in  1  downstream accepts the current point
out_x  out  X_W  point x
out_y  out  Y_W  point y
out_color  out  1  1 = foreground, 0 = background
out_valid  out  1  out_x/out_y/out_color valid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last point is accepted

Behaviour:
- Reset, on any clock edge with reset=1, including mid-render:
  - state goes to IDLE.
  - out_x, out_y, out_color, out_valid, busy and done all go to 0.
  - Internal counters clear.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE, start=1:
  - Latch glyph_bits, origin_x, origin_y, fill_bg, and scale (0 latched as 1).
  - Set pixel index to 0 and go to SCAN.
  - Inputs are not re-sampled during a render.
- SCAN: one cycle per glyph pixel.
  - If the pixel is drawn (bit=1, or fill_bg=1), go to EMIT with sub-counters sx=sy=0.
  - Otherwise advance the index. After index FONT_W*FONT_H-1, go to DONE.
- EMIT:
  - out_valid=1.
  - out_x = origin_x + col*scale + sx, truncated to X_W (wraps modulo 2^X_W).
  - out_y = origin_y + row*scale + sy, truncated to Y_W (wraps modulo 2^Y_W).
  - out_color = glyph bit.
  - Outputs are registered and held stable while out_ready=0.
  - On out_ready=1, advance sx first, then sy (row-major inside the block).
  - After point (scale-1, scale-1) is accepted, advance the index and go to SCAN, or to DONE if this was the last index.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start while busy is ignored. start in the DONE cycle is ignored. start on the first IDLE cycle after DONE is accepted.
- Timing with out_ready held high and start accepted at edge T:
  - An undrawn pixel costs 1 cycle; a drawn pixel costs 1+scale^2 cycles.
  - done is high in cycle T+1+sum(costs).
- Multiplications col*scale and row*scale are computed at full width, then truncated.

Test Plan:
- Empty glyph: glyph_bits=0, fill_bg=0, scale=1, start at cycle 0 -> out_valid never high, busy high cycles 1..36, done high in cycle 36 only.
- Single pixel, bit 0 set, origin (10,20), scale=2, ready=1 -> exactly 4 points (10,20),(11,20),(10,21),(11,21) with color=1, done 40 cycles after start.
- Last pixel, bit 34 set (row 6, col 4), origin (0,0), scale=0 -> one point (4,6), proving scale=0 behaves as 1.
- fill_bg=1, glyph 0, scale=1 -> 35 points with color=0 in row-major order from (ox,oy) to (ox+4,oy+6).
- Backpressure: bit 0 set, scale=2, ready low for 3 cycles after the first valid -> point (x0,y0) held unchanged for those cycles, total 4 points, none duplicated or lost.
- Wrap and robustness:
  - origin_x=254, scale=2, bit 1 set -> x values 0 and 1 (wrap).
  - Assert reset during EMIT -> next cycle all outputs 0 and IDLE.
  - start while busy -> ignored.
